mod_seq_ctrl: RTL and testbench

MOD_SEQ_CTRL -- requirements
Module: mod_seq_ctrl

---
 rtl/mod_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mod_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_seq_ctrl.sv
// Modulator mode-switch sequencer: aligns mode changes to oscillator sample ticks, mutes the
// output while the multiplier path settles, and optionally steps through modes automatically.
module mod_seq_ctrl #(
  parameter int unsigned MULT_LAT = 2,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              req_valid,
  input  logic [1:0]        req_mode,
  output logic              req_ready,
  input  logic              seq_en,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [1:0]        mod_sel,
  output logic              mute,
  output logic              out_valid,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StWaitTick, StMute, StSettle} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mod_sel_q, mod_sel_d;
  logic [1:0]        pend_q, pend_d;
  logic [3:0]        settle_q, settle_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic              seq_on;
  logic              auto_hit;
  logic              switch_done;
  logic [HOLD_W:0]   hold_next;

  assign seq_on    = seq_en && (hold_len != '0);
  assign hold_next = {1'b0, hold_q} + (HOLD_W + 1)'(1);
  // The tick that brings the count up to hold_len fires the internal request itself.
  assign auto_hit  = (state_q == StIdle) && seq_on && sample_tick &&
                     (hold_next >= {1'b0, hold_len});

  always_comb begin
    state_d     = state_q;
    mod_sel_d   = mod_sel_q;
    pend_d      = pend_q;
    settle_d    = settle_q;
    switch_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        // External requests win over a coincident internal one.
        if (req_valid) begin
          if (req_mode != mod_sel_q) begin
            pend_d  = req_mode;
            state_d = StWaitTick;
          end
        end else if (auto_hit) begin
          pend_d  = mod_sel_q + 2'd1;
          state_d = StWaitTick;
        end
      end
      StWaitTick: begin
        if (sample_tick) begin
          state_d = StMute;
        end
      end
      StMute: begin
        mod_sel_d = pend_q;
        settle_d  = '0;
        state_d   = StSettle;
      end
      StSettle: begin
        if (settle_q == 4'(MULT_LAT - 1)) begin
          state_d     = StIdle;
          switch_done = 1'b1;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    if (!seq_on || switch_done) begin
      hold_d = '0;
    end else if ((state_q == StIdle) && sample_tick) begin
      if (auto_hit) begin
        hold_d = '0;
      end else if (hold_q != '1) begin
        hold_d = hold_next[HOLD_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mod_sel_q <= 2'b00;
      pend_q    <= 2'b00;
      settle_q  <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      mod_sel_q <= mod_sel_d;
      pend_q    <= pend_d;
      settle_q  <= settle_d;
      hold_q    <= hold_d;
    end
  end

  assign mod_sel   = mod_sel_q;
  assign mute      = (state_q == StMute) || (state_q == StSettle);
  assign out_valid = !mute;
  assign busy      = (state_q != StIdle);
  assign req_ready = (state_q == StIdle);

endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Self-checking bench for mod_seq_ctrl: directed scenarios plus a randomized run scored against
// a transaction-level model of mode switches.
module tb_mod_seq_ctrl;

  localparam int unsigned MULT_LAT = 2;
  localparam int unsigned HOLD_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic              req_valid = 1'b0;
  logic [1:0]        req_mode = 2'b00;
  logic              seq_en = 1'b0;
  logic [HOLD_W-1:0] hold_len = '0;
  logic              req_ready;
  logic [1:0]        mod_sel;
  logic              mute;
  logic              out_valid;
  logic              busy;

  mod_seq_ctrl #(
    .MULT_LAT (MULT_LAT),
    .HOLD_W   (HOLD_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_ready   (req_ready),
    .seq_en      (seq_en),
    .hold_len    (hold_len),
    .mod_sel     (mod_sel),
    .mute        (mute),
    .out_valid   (out_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] mode;
    int         at;
  } exp_t;

  exp_t       sb_q[$];
  bit         mon_en = 1'b0;
  logic [1:0] mon_last = 2'b00;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    sample_tick = 1'b0;
    req_valid   = 1'b0;
    req_mode    = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    seq_en   = 1'b0;
    hold_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Steps until the controller returns to idle; reports how many cycles that took.
  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic tick_pulse();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // Monitor: every observed mod_sel change must match the next predicted switch.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && (mod_sel !== mon_last)) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_change", int'(mod_sel), int'(mon_last));
        end else begin
          e = sb_q.pop_front();
          check("sb_mode", int'(mod_sel), int'(e.mode));
          check("sb_cycle", cyc, e.at);
        end
        mon_last = mod_sel;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  n;
    int  k;
    int  ticks;
    bit  saw01;
    logic [1:0] last;
    int  m_mode, m_pend, m_mute, m_hold;
    bit  m_wait, idle, se_on, auto;
    exp_t e;

    // Reset values while rst_n is low, before any clock edge.
    #1;
    check("rst_mod_sel", int'(mod_sel), 0);
    check("rst_mute", int'(mute), 0);
    check("rst_out_valid", int'(out_valid), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(req_ready), 1);
    do_reset();

    // Basic switch 00 -> 01, tick at cycle 3.
    req_valid = 1'b1;
    req_mode  = 2'b01;
    check("c0_ready", int'(req_ready), 1);
    step();
    drive_idle();
    check("c1_busy", int'(busy), 1);
    check("c1_ready", int'(req_ready), 0);
    check("c1_mute", int'(mute), 0);
    step();
    step();
    sample_tick = 1'b1;
    check("c3_mute", int'(mute), 0);
    step();
    sample_tick = 1'b0;
    check("c4_mute", int'(mute), 1);
    check("c4_mod_sel", int'(mod_sel), 0);
    check("c4_out_valid", int'(out_valid), 0);
    step();
    check("c5_mod_sel", int'(mod_sel), 1);
    check("c5_mute", int'(mute), 1);
    step();
    check("c6_mute", int'(mute), 1);
    step();
    check("c7_mute", int'(mute), 0);
    check("c7_ready", int'(req_ready), 1);
    check("c7_busy", int'(busy), 0);
    check("c7_out_valid", int'(out_valid), 1);

    // A tick on the acceptance cycle must not count; ticks in MUTE/SETTLE ignored.
    req_valid   = 1'b1;
    req_mode    = 2'b10;
    sample_tick = 1'b1;
    step();
    drive_idle();
    repeat (4) step();
    check("acc_tick_busy", int'(busy), 1);
    check("acc_tick_mute", int'(mute), 0);
    check("acc_tick_mod_sel", int'(mod_sel), 1);
    sample_tick = 1'b1;
    step();
    wait_idle("sw10_timeout", n);
    sample_tick = 1'b0;
    check("sw10_mute_len", n, MULT_LAT + 1);
    check("sw10_mod_sel", int'(mod_sel), 2);

    // Same-mode request: stays idle, nothing changes.
    req_valid = 1'b1;
    req_mode  = 2'b10;
    for (int i = 0; i < 3; i++) begin
      check("same_ready", int'(req_ready), 1);
      step();
      check("same_busy", int'(busy), 0);
      check("same_mute", int'(mute), 0);
      check("same_mod_sel", int'(mod_sel), 2);
    end
    drive_idle();

    // Request held high in WAIT_TICK with a different mode is not accepted until idle.
    req_valid = 1'b1;
    req_mode  = 2'b11;
    step();
    req_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check("hold_ready", int'(req_ready), 0);
      check("hold_mod_sel", int'(mod_sel), 2);
      step();
    end
    tick_pulse();
    wait_idle("sw11_timeout", n);
    check("sw11_mute_len", n, MULT_LAT + 1);
    check("sw11_ready", int'(req_ready), 1);
    check("sw11_mod_sel", int'(mod_sel), 3);
    step();
    req_valid = 1'b0;
    check("second_acc_busy", int'(busy), 1);
    check("second_acc_ready", int'(req_ready), 0);
    tick_pulse();
    wait_idle("sw00_timeout", n);
    check("sw00_mod_sel", int'(mod_sel), 0);

    // Asynchronous reset during SETTLE after switching to 11.
    req_valid = 1'b1;
    req_mode  = 2'b11;
    step();
    req_valid = 1'b0;
    tick_pulse();
    step();
    check("pre_rst_mod_sel", int'(mod_sel), 3);
    check("pre_rst_mute", int'(mute), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mod_sel", int'(mod_sel), 0);
    check("async_rst_mute", int'(mute), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(req_ready), 1);
    do_reset();
    repeat (3) step();
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_mod_sel", int'(mod_sel), 0);

    // External request 10 coincides with internal auto-request (would be 01).
    seq_en      = 1'b1;
    hold_len    = 8'd1;
    req_valid   = 1'b1;
    req_mode    = 2'b10;
    sample_tick = 1'b1;
    step();
    drive_idle();
    seq_en = 1'b0;
    saw01  = 1'b0;
    tick_pulse();
    for (int i = 0; i < 6; i++) begin
      if (mod_sel == 2'b01) saw01 = 1'b1;
      step();
    end
    check("prio_saw01", int'(saw01), 0);
    check("prio_mod_sel", int'(mod_sel), 2);
    check("prio_busy", int'(busy), 0);

    // Auto-sequence: hold_len=3, tick every 10 cycles.
    do_reset();
    seq_en   = 1'b1;
    hold_len = 8'd3;
    last     = 2'b00;
    k        = 0;
    ticks    = 0;
    for (int i = 0; i < 160; i++) begin
      if (mod_sel != last) begin
        check("auto_mode", int'(mod_sel), (int'(last) + 1) % 4);
        check("auto_ticks", ticks, 4);
        last  = mod_sel;
        ticks = 0;
        k++;
      end
      sample_tick = (i % 10 == 0);
      if (sample_tick) ticks++;
      step();
    end
    check("auto_steps", k, 4);
    check("auto_final", int'(mod_sel), 0);

    // Randomized run against the switch-level model.
    do_reset();
    m_mode   = 0;
    m_pend   = 0;
    m_mute   = 0;
    m_hold   = 0;
    m_wait   = 1'b0;
    mon_last = 2'b00;
    mon_en   = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      idle = !m_wait && (m_mute == 0);
      check("rnd_ready", int'(req_ready), int'(idle));
      check("rnd_mute", int'(mute), int'(m_mute > 0));

      if (c % 250 == 0) begin
        seq_en   = ($urandom_range(0, 3) != 0);
        hold_len = HOLD_W'($urandom_range(0, 4));
      end
      sample_tick = ($urandom_range(0, 3) == 0);
      req_valid   = ($urandom_range(0, 5) == 0);
      req_mode    = 2'($urandom_range(0, 3));

      se_on = seq_en && (hold_len != 0);
      if (idle) begin
        auto = se_on && sample_tick && (m_hold + 1 >= int'(hold_len));
        if (req_valid) begin
          if (int'(req_mode) != m_mode) begin
            m_pend = int'(req_mode);
            m_wait = 1'b1;
          end
        end else if (auto) begin
          m_pend = (m_mode + 1) % 4;
          m_wait = 1'b1;
        end
        if (sample_tick) m_hold = auto ? 0 : ((m_hold < 255) ? m_hold + 1 : m_hold);
      end else if (m_wait) begin
        if (sample_tick) begin
          m_wait = 1'b0;
          m_mute = MULT_LAT + 1;
        end
      end else begin
        if (m_mute == MULT_LAT + 1) begin
          m_mode = m_pend;
          e.mode = 2'(m_pend);
          e.at   = cyc + 1;
          sb_q.push_back(e);
        end
        m_mute--;
        if (m_mute == 0) m_hold = 0;
      end
      if (!se_on) m_hold = 0;
      step();
    end
    drive_idle();
    seq_en = 1'b0;
    repeat (2) step();
    mon_en = 1'b0;
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
